bit_align_mc: RTL and testbench

BIT_ALIGN_MC -- requirements
Module: bit_align_mc

---
 rtl/bit_align_pkg.sv | 30 +++
 rtl/bit_align_ch.sv | 116 +++++++++++
 rtl/bit_align_mc.sv | 44 ++++
 tb/tb_bit_align_mc.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_align_pkg.sv
// Shared types and helpers for the multi-channel bit aligner: channel FSM states,
// shift saturation and width-generic rotate-left.
package bit_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_VERIFY,
    ST_LOCKED,
    ST_FAIL
  } align_st_e;

  localparam int MAX_W = 32;

  // Rotate-left of the low w bits of d by s (s < w); bits above w return zero.
  function automatic logic [MAX_W-1:0] rot_l(input logic [MAX_W-1:0] d, input int s, input int w);
    logic [2*MAX_W-1:0] m;
    logic [2*MAX_W-1:0] dm;
    logic [2*MAX_W-1:0] r;
    m  = (64'd1 << w) - 64'd1;
    dm = {32'd0, d} & m;
    r  = ((dm << s) | (dm >> (w - s))) & m;
    return r[MAX_W-1:0];
  endfunction

  function automatic int sat_shift(input int v, input int w);
    return (v >= w) ? (w - 1) : v;
  endfunction

endpackage

// File: rtl/bit_align_ch.sv
// One alignment channel: sweeps the rotation until TRAIN_PAT is seen MATCH_CNT times in a row.
// Optional BIT_ALIGN_LOCK_MON_EN drops lock after 2 consecutive bad words while LOCKED.
module bit_align_ch
  import bit_align_pkg::*;
#(
  parameter int              DATA_W    = 24,
  parameter logic [DATA_W-1:0] TRAIN_PAT = 24'hFFF000,
  parameter int              MATCH_CNT = 4,
  localparam int             SHIFT_W   = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               data_rst,
  input  logic [DATA_W-1:0]  din,
  input  logic [SHIFT_W-1:0] extra_shift,
  input  logic               align_to_fclk,
  input  logic               align_start,
  output logic [SHIFT_W-1:0] shift_out,
  output logic [DATA_W-1:0]  dout,
  output logic               align_done,
  output logic               align_err
);

  align_st_e          state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [MAX_W-1:0]   rot_full;
  logic [7:0]         cnt_nx;
  logic               hit;
  logic               last;
`ifdef BIT_ALIGN_LOCK_MON_EN
  logic               bad_q, bad_d;
`endif

  always_comb begin
    rot_full = rot_l(MAX_W'(din), int'(shift_q), DATA_W);
    dout_d   = rot_full[DATA_W-1:0];
    hit      = (dout_d == TRAIN_PAT);
    last     = (shift_q == SHIFT_W'(DATA_W - 1));
    cnt_nx   = (state_q == ST_SEARCH) ? 8'd1 : (cnt_q + 8'd1);

    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
`ifdef BIT_ALIGN_LOCK_MON_EN
    bad_d   = bad_q;
`endif

    // A start pulse overrides whatever the FSM would otherwise do this cycle.
    if (align_start) begin
      cnt_d = 8'd0;
`ifdef BIT_ALIGN_LOCK_MON_EN
      bad_d = 1'b0;
`endif
      if (align_to_fclk) begin
        shift_d = SHIFT_W'(sat_shift(int'(extra_shift), DATA_W));
        state_d = ST_LOCKED;
      end else begin
        shift_d = '0;
        state_d = ST_SEARCH;
      end
    end else begin
      case (state_q)
        ST_SEARCH, ST_VERIFY: begin
          if (hit) begin
            cnt_d   = cnt_nx;
            state_d = (cnt_nx >= 8'(MATCH_CNT)) ? ST_LOCKED : ST_VERIFY;
          end else begin
            cnt_d = 8'd0;
            if (last) begin
              shift_d = '0;
              state_d = ST_FAIL;
            end else begin
              shift_d = shift_q + 1'b1;
              state_d = ST_SEARCH;
            end
          end
        end
        ST_LOCKED: begin
`ifdef BIT_ALIGN_LOCK_MON_EN
          bad_d = ~hit;
          if (!hit && bad_q) state_d = ST_FAIL;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge data_rst) begin
    if (data_rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= 8'd0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

`ifdef BIT_ALIGN_LOCK_MON_EN
  always_ff @(posedge clk or posedge data_rst) begin
    if (data_rst) bad_q <= 1'b0;
    else          bad_q <= bad_d;
  end
`endif

  assign shift_out  = shift_q;
  assign dout       = dout_q;
  assign align_done = (state_q == ST_LOCKED);
  assign align_err  = (state_q == ST_FAIL);

endmodule

// File: rtl/bit_align_mc.sv
// Multi-channel bit aligner top: slices the packed buses into per-channel aligners
// and reduces their lock flags. Lock monitor option: BIT_ALIGN_LOCK_MON_EN.
module bit_align_mc #(
  parameter int                DATA_W    = 24,
  parameter int                CH_NUM    = 4,
  parameter logic [DATA_W-1:0] TRAIN_PAT = 24'hFFF000,
  parameter int                MATCH_CNT = 4,
  localparam int               SHIFT_W   = $clog2(DATA_W)
) (
  input  logic                        clk,
  input  logic                        data_rst,
  input  logic [CH_NUM*DATA_W-1:0]    din,
  input  logic [CH_NUM*SHIFT_W-1:0]   extra_shift,
  input  logic                        align_to_fclk,
  input  logic                        align_start,
  output logic [CH_NUM*SHIFT_W-1:0]   shift_out,
  output logic [CH_NUM*DATA_W-1:0]    dout,
  output logic [CH_NUM-1:0]           align_done,
  output logic                        align_done_all,
  output logic [CH_NUM-1:0]           align_err
);

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    bit_align_ch #(
      .DATA_W    (DATA_W),
      .TRAIN_PAT (TRAIN_PAT),
      .MATCH_CNT (MATCH_CNT)
    ) u_ch (
      .clk           (clk),
      .data_rst      (data_rst),
      .din           (din[g*DATA_W +: DATA_W]),
      .extra_shift   (extra_shift[g*SHIFT_W +: SHIFT_W]),
      .align_to_fclk (align_to_fclk),
      .align_start   (align_start),
      .shift_out     (shift_out[g*SHIFT_W +: SHIFT_W]),
      .dout          (dout[g*DATA_W +: DATA_W]),
      .align_done    (align_done[g]),
      .align_err     (align_err[g])
    );
  end

  assign align_done_all = &align_done;

endmodule

// File: tb/tb_bit_align_mc.sv
// Randomized and directed bench for bit_align_mc against a search-by-rotation reference model.
module tb_bit_align_mc;

  localparam int          DW   = 24;
  localparam int          CH   = 4;
  localparam int          SW   = 5;
  localparam int          MC   = 4;
  localparam logic [23:0] PAT  = 24'hFFF000;
  localparam int          BUDG = DW + MC + 1;

  logic               clk = 1'b0;
  logic               data_rst;
  logic [CH*DW-1:0]   din;
  logic [CH*SW-1:0]   extra_shift;
  logic               align_to_fclk;
  logic               align_start;
  logic [CH*SW-1:0]   shift_out;
  logic [CH*DW-1:0]   dout;
  logic [CH-1:0]      align_done;
  logic               align_done_all;
  logic [CH-1:0]      align_err;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cyc [CH];
  int err_cyc  [CH];

  bit_align_mc #(.DATA_W(DW), .CH_NUM(CH), .TRAIN_PAT(PAT), .MATCH_CNT(MC)) dut (
    .clk            (clk),
    .data_rst       (data_rst),
    .din            (din),
    .extra_shift    (extra_shift),
    .align_to_fclk  (align_to_fclk),
    .align_start    (align_start),
    .shift_out      (shift_out),
    .dout           (dout),
    .align_done     (align_done),
    .align_done_all (align_done_all),
    .align_err      (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] rotl24(input logic [23:0] d, input int s);
    logic [47:0] dd;
    dd = {d, d} << s;
    return dd[47:24];
  endfunction

  // Reference: smallest rotation that turns d into the training word, or -1.
  function automatic int lock_shift(input logic [23:0] d);
    for (int s = 0; s < DW; s++)
      if (rotl24(d, s) == PAT) return s;
    return -1;
  endfunction

  function automatic logic [23:0] dout_ch(input int c);
    return dout[c*DW +: DW];
  endfunction

  function automatic logic [23:0] din_ch(input int c);
    return din[c*DW +: DW];
  endfunction

  function automatic int shift_ch(input int c);
    return int'(shift_out[c*SW +: SW]);
  endfunction

  task automatic pulse_start(input logic mode);
    align_to_fclk = mode;
    align_start   = 1'b1;
    @(negedge clk);
    align_start   = 1'b0;
  endtask

  // Record, per channel, the first cycle after the start edge where done/err appears.
  task automatic run_cycles(input int n);
    for (int c = 0; c < CH; c++) begin
      done_cyc[c] = -1;
      err_cyc[c]  = -1;
    end
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (align_done[c] && done_cyc[c] < 0) done_cyc[c] = k;
        if (align_err[c]  && err_cyc[c]  < 0) err_cyc[c]  = k;
      end
    end
  endtask

  task automatic check_search(input string tag);
    int s;
    logic all;
    all = 1'b1;
    for (int c = 0; c < CH; c++) begin
      s = lock_shift(din_ch(c));
      if (s >= 0) begin
        chk($sformatf("%s_ch%0d_done_cyc", tag, c), done_cyc[c], s + MC);
        chk($sformatf("%s_ch%0d_shift", tag, c), shift_ch(c), s);
        chk($sformatf("%s_ch%0d_dout", tag, c), dout_ch(c), PAT);
        chk($sformatf("%s_ch%0d_err", tag, c), align_err[c], 1'b0);
      end else begin
        all = 1'b0;
        chk($sformatf("%s_ch%0d_err_cyc", tag, c), err_cyc[c], DW);
        chk($sformatf("%s_ch%0d_shift", tag, c), shift_ch(c), 0);
        chk($sformatf("%s_ch%0d_dout", tag, c), dout_ch(c), din_ch(c));
        chk($sformatf("%s_ch%0d_done", tag, c), align_done[c], 1'b0);
      end
    end
    chk($sformatf("%s_done_all", tag), align_done_all, all);
  endtask

  initial begin
    int sat;
    data_rst      = 1'b1;
    din           = '0;
    extra_shift   = '0;
    align_to_fclk = 1'b0;
    align_start   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_shift", shift_out, 0);
    chk("rst_dout", dout, 0);
    chk("rst_done", align_done, 0);
    chk("rst_done_all", align_done_all, 0);
    chk("rst_err", align_err, 0);
    data_rst = 1'b0;
    @(negedge clk);

    // Directed search: ch0 locks at 1, ch1 at 8, ch2 never, ch3 at 5.
    din[0*DW +: DW] = 24'h7FF800;
    din[1*DW +: DW] = 24'h00FFF0;
    din[2*DW +: DW] = 24'h3FC000;
    din[3*DW +: DW] = rotl24(PAT, DW - 5);
    pulse_start(1'b0);
    run_cycles(BUDG);
    chk("dir_ch0_within7", (done_cyc[0] > 0 && done_cyc[0] <= 7), 1'b1);
    chk("dir_ch0_shift", shift_ch(0), 1);
    chk("dir_ch1_shift", shift_ch(1), 8);
    chk("dir_ch2_err", align_err[2], 1'b1);
    chk("dir_done_all", align_done_all, 1'b0);
    check_search("dir");

    // Randomized channels: mostly rotated training words, sometimes noise.
    for (int it = 0; it < 10; it++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 2) != 0)
          din[c*DW +: DW] = rotl24(PAT, $urandom_range(0, DW - 1));
        else
          din[c*DW +: DW] = 24'($urandom);
      end
      pulse_start(1'b0);
      run_cycles(BUDG);
      check_search($sformatf("rand%0d", it));
    end

    // Manual shift load with saturation.
    din[0*DW +: DW] = 24'h123456;
    extra_shift[0*SW +: SW] = 5'd3;
    extra_shift[1*SW +: SW] = 5'd31;
    extra_shift[2*SW +: SW] = 5'($urandom_range(0, 31));
    extra_shift[3*SW +: SW] = 5'($urandom_range(0, 31));
    pulse_start(1'b1);
    chk("man_done", align_done, 4'hF);
    chk("man_done_all", align_done_all, 1'b1);
    chk("man_err", align_err, 4'h0);
    for (int c = 0; c < CH; c++) begin
      sat = int'(extra_shift[c*SW +: SW]);
      if (sat > DW - 1) sat = DW - 1;
      chk($sformatf("man_ch%0d_shift", c), shift_ch(c), sat);
    end
    @(negedge clk);
    chk("man_ch0_dout", dout_ch(0), 24'h91A2B0);
    chk("man_ch1_dout", dout_ch(1), rotl24(din_ch(1), 23));

    // One corrupted word on the third match of ch0: sweep resumes at shift 2, then fails.
    din = {CH{24'h7FF800}};
    pulse_start(1'b0);
    err_cyc[0] = -1;
    for (int k = 1; k <= 30; k++) begin
      din[0*DW +: DW] = (k == 4) ? 24'h000000 : 24'h7FF800;
      @(negedge clk);
      if (k == 4) begin
        chk("cor_shift_resume", shift_ch(0), 2);
        chk("cor_not_done", align_done[0], 1'b0);
      end
      if (align_err[0] && err_cyc[0] < 0) err_cyc[0] = k;
    end
    chk("cor_err_cyc", err_cyc[0], 26);
    chk("cor_shift_fail", shift_ch(0), 0);
    chk("cor_ch1_done", align_done[1], 1'b1);

    // Restart mid-search: ch0 needs shift 20.
    din[0*DW +: DW] = rotl24(PAT, 4);
    pulse_start(1'b0);
    run_cycles(6);
    chk("rep_mid_shift", shift_ch(0), 6);
    pulse_start(1'b0);
    chk("rep_restart_shift", shift_ch(0), 0);
    run_cycles(BUDG);
    chk("rep_done_cyc", done_cyc[0], 21 + MC - 1);
    chk("rep_shift", shift_ch(0), 20);

    // Asynchronous reset mid-search, then no activity until a new start.
    pulse_start(1'b0);
    run_cycles(5);
    #2 data_rst = 1'b1;
    #1;
    chk("arst_shift", shift_out, 0);
    chk("arst_dout", dout, 0);
    chk("arst_done", align_done, 0);
    chk("arst_err", align_err, 0);
    chk("arst_done_all", align_done_all, 0);
    @(negedge clk);
    data_rst = 1'b0;
    run_cycles(BUDG);
    chk("idle_done", align_done, 0);
    chk("idle_err", align_err, 0);
    chk("idle_shift", shift_out, 0);

    // Two bad words after lock.
    din[0*DW +: DW] = 24'h7FF800;
    pulse_start(1'b0);
    run_cycles(10);
    chk("mon_locked", align_done[0], 1'b1);
    din[0*DW +: DW] = 24'h000000;
    repeat (2) @(negedge clk);
    din[0*DW +: DW] = 24'h7FF800;
    repeat (3) @(negedge clk);
`ifdef BIT_ALIGN_LOCK_MON_EN
    chk("mon_err", align_err[0], 1'b1);
    chk("mon_done", align_done[0], 1'b0);
`else
    chk("mon_err", align_err[0], 1'b0);
    chk("mon_done", align_done[0], 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
